// File: rtl/fpu_cmd_sequencer_if.sv
// rtl/fpu_cmd_sequencer_if.sv - command, fpu issue and result handshake bundle
interface fpu_cmd_sequencer_if #(
  parameter int TAG_W = 4
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [31:0]      cmd_a;
  logic [31:0]      cmd_b;
  logic [1:0]       cmd_op;
  logic [TAG_W-1:0] cmd_tag;

  logic [31:0]      fpu_a;
  logic [31:0]      fpu_b;
  logic [1:0]       fpu_op;
  logic             fpu_start;
  logic             fpu_done;
  logic [31:0]      fpu_r;

  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;
  logic             res_timeout;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, fpu_done, fpu_r, res_ready,
    output cmd_ready, fpu_a, fpu_b, fpu_op, fpu_start, res_valid, res_data, res_tag, res_timeout
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, fpu_done, fpu_r, res_ready,
    input  cmd_ready, fpu_a, fpu_b, fpu_op, fpu_start, res_valid, res_data, res_tag, res_timeout
  );
endinterface

// File: rtl/fpu_cmd_sequencer.sv
// rtl/fpu_cmd_sequencer.sv - buffers fpu commands, issues them one at a time, returns tagged results
// A watchdog forces a qNaN result when the fpu never reports completion.
module fpu_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  fpu_cmd_sequencer_if.slave         bus,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
  localparam logic [31:0]   QNAN    = 32'h7FC0_0000;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_CLR, WAIT_DONE, RESULT} state_t;

  state_t state_q, state_d;

  logic [31:0]      fifo_a   [DEPTH];
  logic [31:0]      fifo_b   [DEPTH];
  logic [1:0]       fifo_op  [DEPTH];
  logic [TAG_W-1:0] fifo_tag [DEPTH];

  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             cmd_ready_q, busy_q, busy_d;
  logic [WW-1:0]    wd_q, wd_d;

  logic [31:0]      op_a_q, op_b_q;
  logic [1:0]       op_op_q;
  logic [TAG_W-1:0] op_tag_q;

  logic             res_valid_q, res_timeout_q;
  logic [31:0]      res_data_q;
  logic [TAG_W-1:0] res_tag_q;

  logic             push, pop, complete, expire;

  // cmd_ready_q only reflects the registered fill level, so a push never lands on a full FIFO
  assign push = bus.cmd_valid && cmd_ready_q;

  always_comb begin
    state_d  = state_q;
    wd_d     = wd_q;
    pop      = 1'b0;
    complete = 1'b0;
    expire   = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT_CLR;
      end
      WAIT_CLR: begin
        if (wd_q == WD_LAST) begin
          expire  = 1'b1;
          state_d = RESULT;
        end else begin
          wd_d = wd_q + 1'b1;
          if (!bus.fpu_done) state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (bus.fpu_done) begin
          complete = 1'b1;
          state_d  = RESULT;
        end else if (wd_q == WD_LAST) begin
          expire  = 1'b1;
          state_d = RESULT;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      RESULT: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    count_d = count_q + CW'(push) - CW'(pop);
    busy_d  = (state_d != IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wd_q          <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      cmd_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      op_op_q       <= '0;
      op_tag_q      <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_tag_q     <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      count_q     <= count_d;
      cmd_ready_q <= (count_d != CW'(DEPTH));
      busy_q      <= busy_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        op_a_q   <= fifo_a[rd_ptr_q];
        op_b_q   <= fifo_b[rd_ptr_q];
        op_op_q  <= fifo_op[rd_ptr_q];
        op_tag_q <= fifo_tag[rd_ptr_q];
      end
      if (complete) begin
        res_data_q    <= bus.fpu_r;
        res_tag_q     <= op_tag_q;
        res_timeout_q <= 1'b0;
        res_valid_q   <= 1'b1;
      end else if (expire) begin
        res_data_q    <= QNAN;
        res_tag_q     <= op_tag_q;
        res_timeout_q <= 1'b1;
        res_valid_q   <= 1'b1;
      end else if (state_q == RESULT && bus.res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wr_ptr_q]   <= bus.cmd_a;
      fifo_b[wr_ptr_q]   <= bus.cmd_b;
      fifo_op[wr_ptr_q]  <= bus.cmd_op;
      fifo_tag[wr_ptr_q] <= bus.cmd_tag;
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.fpu_a       = op_a_q;
  assign bus.fpu_b       = op_b_q;
  assign bus.fpu_op      = op_op_q;
  assign bus.fpu_start   = (state_q == ISSUE);
  assign bus.res_valid   = res_valid_q;
  assign bus.res_data    = res_data_q;
  assign bus.res_tag     = res_tag_q;
  assign bus.res_timeout = res_timeout_q;
  assign busy            = busy_q;
  assign count           = count_q;

endmodule

// File: tb/tb_fpu_cmd_sequencer.sv
// tb/tb_fpu_cmd_sequencer.sv - directed self-checking bench for fpu_cmd_sequencer
module tb_fpu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [2:0] count;

  int n_vec = 0;
  int n_err = 0;
  int start_cnt = 0;
  int starts_used = 0;

  fpu_cmd_sequencer_if #(.TAG_W(4)) bus ();

  fpu_cmd_sequencer #(.DEPTH(4), .TAG_W(4), .TIMEOUT(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .busy  (busy),
    .count (count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.fpu_start === 1'b1) start_cnt <= start_cnt + 1;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op, input logic [3:0] tag);
    int guard = 0;
    while (bus.cmd_ready !== 1'b1 && guard < 100) begin
      step(1);
      guard++;
    end
    chk("send_ready", {31'd0, bus.cmd_ready}, 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_op    = op;
    bus.cmd_tag   = tag;
    step(1);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_new_start();
    int guard = 0;
    while (start_cnt == starts_used && guard < 100) begin
      step(1);
      guard++;
    end
    chk("start_seen", {31'd0, start_cnt != starts_used}, 32'd1);
    starts_used = start_cnt;
  endtask

  task automatic fpu_run(input logic [31:0] r, input int lat);
    wait_new_start();
    bus.fpu_done = 1'b0;
    step(lat);
    bus.fpu_r    = r;
    bus.fpu_done = 1'b1;
  endtask

  task automatic wait_valid();
    int guard = 0;
    while (bus.res_valid !== 1'b1 && guard < 100) begin
      step(1);
      guard++;
    end
    chk("res_valid_seen", {31'd0, bus.res_valid}, 32'd1);
  endtask

  task automatic get_result(input logic [31:0] data, input logic [3:0] tag, input logic to);
    wait_valid();
    chk("res_data", bus.res_data, data);
    chk("res_tag", {28'd0, bus.res_tag}, {28'd0, tag});
    chk("res_timeout", {31'd0, bus.res_timeout}, {31'd0, to});
    bus.res_ready = 1'b1;
    step(1);
    bus.res_ready = 1'b0;
    chk("res_valid_drop", {31'd0, bus.res_valid}, 32'd0);
  endtask

  initial begin
    int  base;
    int  stable_ok;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_op    = '0;
    bus.cmd_tag   = '0;
    bus.fpu_done  = 1'b0;
    bus.fpu_r     = '0;
    bus.res_ready = 1'b0;
    step(3);
    rst = 1'b0;

    chk("rst_fpu_start", {31'd0, bus.fpu_start}, 32'd0);
    chk("rst_fpu_a", bus.fpu_a, 32'd0);
    chk("rst_fpu_b", bus.fpu_b, 32'd0);
    chk("rst_fpu_op", {30'd0, bus.fpu_op}, 32'd0);
    chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("rst_res_data", bus.res_data, 32'd0);
    chk("rst_res_tag", {28'd0, bus.res_tag}, 32'd0);
    chk("rst_res_timeout", {31'd0, bus.res_timeout}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("rst_count", {29'd0, count}, 32'd0);

    // single add: accept at edge T, start sampled high at edge T+2 only
    base          = start_cnt;
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = 32'h3F80_0000;
    bus.cmd_b     = 32'h4000_0000;
    bus.cmd_op    = 2'b00;
    bus.cmd_tag   = 4'd5;
    step(1);
    bus.cmd_valid = 1'b0;
    chk("add_count", {29'd0, count}, 32'd1);
    chk("add_busy", {31'd0, busy}, 32'd1);
    chk("add_start_t1", {31'd0, bus.fpu_start}, 32'd0);
    step(1);
    chk("add_start_t2", {31'd0, bus.fpu_start}, 32'd1);
    chk("add_fpu_a", bus.fpu_a, 32'h3F80_0000);
    chk("add_fpu_b", bus.fpu_b, 32'h4000_0000);
    chk("add_fpu_op", {30'd0, bus.fpu_op}, 32'd0);
    step(1);
    chk("add_start_t3", {31'd0, bus.fpu_start}, 32'd0);
    chk("add_one_pulse", start_cnt - base, 32'd1);
    fpu_run(32'h4040_0000, 2);
    get_result(32'h4040_0000, 4'd5, 1'b0);
    chk("add_idle_busy", {31'd0, busy}, 32'd0);

    // fill: an unconsumed result blocks issue, so four commands fill the FIFO
    send(32'h3F80_0000, 32'h3F80_0000, 2'b00, 4'd15);
    fpu_run(32'h4000_0000, 1);
    wait_valid();
    for (int i = 0; i < 4; i++) send(32'h4000_0000 + i, 32'h3F80_0000, 2'(i), 4'(i));
    chk("fill_count", {29'd0, count}, 32'd4);
    chk("fill_ready", {31'd0, bus.cmd_ready}, 32'd0);
    bus.cmd_valid = 1'b1;
    bus.cmd_tag   = 4'd4;
    step(3);
    bus.cmd_valid = 1'b0;
    chk("fill_held_off", {29'd0, count}, 32'd4);
    chk("fill_no_start", start_cnt - starts_used, 32'd0);
    get_result(32'h4000_0000, 4'd15, 1'b0);
    send(32'h4100_0000, 32'h3F80_0000, 2'b01, 4'd4);
    for (int i = 0; i < 5; i++) begin
      fpu_run(32'h4100_0000 | i, 2);
      get_result(32'h4100_0000 | i, 4'(i), 1'b0);
    end

    // backpressure: result held for 10 cycles, queued command must not start
    send(32'h4000_0000, 32'h4040_0000, 2'b10, 4'd7);
    send(32'h3F80_0000, 32'h3F80_0000, 2'b11, 4'd8);
    fpu_run(32'h40C0_0000, 2);
    wait_valid();
    base      = start_cnt;
    stable_ok = 1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (bus.res_valid !== 1'b1 || bus.res_data !== 32'h40C0_0000 || bus.res_tag !== 4'd7) stable_ok = 0;
    end
    chk("bp_stable", stable_ok, 32'd1);
    chk("bp_no_start", start_cnt - base, 32'd0);
    chk("bp_fpu_a", bus.fpu_a, 32'h4000_0000);
    chk("bp_fpu_op", {30'd0, bus.fpu_op}, 32'd2);
    get_result(32'h40C0_0000, 4'd7, 1'b0);
    fpu_run(32'h3F80_0000, 1);
    get_result(32'h3F80_0000, 4'd8, 1'b0);

    // stale done: done stays high across issue and must first fall
    bus.fpu_r = 32'hDEAD_BEEF;
    send(32'h4120_0000, 32'h3F80_0000, 2'b10, 4'd9);
    wait_new_start();
    step(3);
    chk("stale_no_res", {31'd0, bus.res_valid}, 32'd0);
    bus.fpu_done = 1'b0;
    step(2);
    chk("stale_low_no_res", {31'd0, bus.res_valid}, 32'd0);
    bus.fpu_r    = 32'h4120_0000;
    bus.fpu_done = 1'b1;
    step(1);
    chk("stale_latency", {31'd0, bus.res_valid}, 32'd1);
    get_result(32'h4120_0000, 4'd9, 1'b0);

    // timeout: 16 wait cycles without done forces qNaN
    send(32'h3F80_0000, 32'h4000_0000, 2'b11, 4'd3);
    wait_new_start();
    bus.fpu_done = 1'b0;
    step(15);
    chk("to_not_yet", {31'd0, bus.res_valid}, 32'd0);
    step(1);
    chk("to_valid", {31'd0, bus.res_valid}, 32'd1);
    get_result(32'h7FC0_0000, 4'd3, 1'b1);
    send(32'h3F80_0000, 32'h3F80_0000, 2'b00, 4'd4);
    fpu_run(32'h4000_0000, 3);
    get_result(32'h4000_0000, 4'd4, 1'b0);

    // reset mid-operation with two commands queued
    send(32'h3F80_0000, 32'h3F80_0000, 2'b00, 4'd10);
    send(32'h3F80_0000, 32'h3F80_0000, 2'b00, 4'd11);
    send(32'h3F80_0000, 32'h3F80_0000, 2'b00, 4'd12);
    wait_new_start();
    bus.fpu_done = 1'b0;
    step(2);
    chk("rmid_count", {29'd0, count}, 32'd2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rmid_busy", {31'd0, busy}, 32'd0);
    chk("rmid_count0", {29'd0, count}, 32'd0);
    chk("rmid_res_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("rmid_start", {31'd0, bus.fpu_start}, 32'd0);
    chk("rmid_ready", {31'd0, bus.cmd_ready}, 32'd1);
    bus.fpu_r    = 32'h1234_5678;
    bus.fpu_done = 1'b1;
    step(5);
    chk("rmid_late_done", {31'd0, bus.res_valid}, 32'd0);
    chk("rmid_no_start", start_cnt - starts_used, 32'd0);
    chk("rmid_idle", {31'd0, busy}, 32'd0);
    send(32'h4000_0000, 32'h4000_0000, 2'b10, 4'd2);
    fpu_run(32'h4080_0000, 2);
    get_result(32'h4080_0000, 4'd2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=stuck expected=finish");
    $fatal(1, "global time limit");
  end

endmodule
